// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: flags each occurrence of PATTERN in the en-qualified serial stream din and keeps a saturating match count.
// Detection overlaps only when SEQ_DETECT_OVERLAP_EN is defined; otherwise each match needs LEN fresh bits.
module seq_pattern_detector #(
  parameter int unsigned      LEN     = 5,
  parameter logic [LEN-1:0]   PATTERN = 5'b00101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);
  localparam int unsigned FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);
  localparam logic [FW-1:0] LAST = FW'(LEN - 1);
  // The oldest history bit is shifted out before it is ever compared, so only LEN-1 bits are stored.
  logic [LEN-2:0]   hist;
  logic [LEN-1:0]   window;
  logic [FW-1:0]    fill, fill_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hit;
  always_comb begin
    window  = {hist, din};
    hit     = en && !clear && fill >= LAST && window == PATTERN;
    cnt_nxt = (hit && !(&match_count)) ? match_count + CNT_W'(1) : match_count;
`ifdef SEQ_DETECT_OVERLAP_EN
    fill_nxt = (fill == FULL) ? FULL : fill + FW'(1);
`else
    fill_nxt = hit ? '0 : (fill == FULL) ? FULL : fill + FW'(1);
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match       <= hit;
      match_count <= cnt_nxt;
      count_sat   <= &cnt_nxt;
      if (en) begin
        hist <= window[LEN-2:0];
        fill <= fill_nxt;
      end
    end
  end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed checks of burst detection, fill guard, overlap, en gaps, saturation/clear and async reset.
module tb_seq_pattern_detector;
  logic       clk = 1'b0, reset = 1'b0, din = 1'b0, en = 1'b0, clear = 1'b0;
  logic       d_match, o_match, s_match, d_sat, o_sat, s_sat;
  logic [7:0] d_cnt, o_cnt;
  logic [1:0] s_cnt;
  int         n_cmp = 0, n_err = 0;
  seq_pattern_detector u_d (.clk(clk), .reset(reset), .din(din), .en(en), .clear(clear),
    .match(d_match), .match_count(d_cnt), .count_sat(d_sat));
  seq_pattern_detector #(.LEN(3), .PATTERN(3'b101)) u_o (.clk(clk), .reset(reset), .din(din), .en(en),
    .clear(clear), .match(o_match), .match_count(o_cnt), .count_sat(o_sat));
  seq_pattern_detector #(.CNT_W(2)) u_s (.clk(clk), .reset(reset), .din(din), .en(en), .clear(clear),
    .match(s_match), .match_count(s_cnt), .count_sat(s_sat));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic d, input logic e, input logic c);
    @(negedge clk);
    din = d; en = e; clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    din = 1'b0; en = 1'b0; clear = 1'b0; reset = 1'b1;
    #2 reset = 1'b0;
  endtask
  // Sends the first four bits of 00101, expecting no match on the 5-bit instances.
  task automatic prefix(input string tag);
    logic [4:0] p;
    p = 5'b00101;
    for (int i = 4; i >= 1; i--) begin
      step(p[i], 1'b1, 1'b0);
      check({tag, "_nomatch"}, {d_match, s_match}, 2'b00);
    end
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_match", {d_match, o_match, s_match}, 3'b000);
    check("rst_cnt", {d_cnt, o_cnt, s_cnt}, 18'd0);
    check("rst_sat", {d_sat, o_sat, s_sat}, 3'b000);
    @(negedge clk) reset = 1'b0;
    prefix("burst");
    step(1'b1, 1'b1, 1'b0);
    check("burst_match", d_match, 1'b1);
    check("burst_cnt", d_cnt, 8'd1);
    step(1'b0, 1'b1, 1'b0);
    check("burst_pulse_end", d_match, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("guard_101", d_match, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("guard_idle0", d_match, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("guard_idle1", d_match, 1'b0);
    check("guard_cnt0", d_cnt, 8'd0);
    prefix("guard");
    step(1'b1, 1'b1, 1'b0);
    check("guard_match", d_match, 1'b1);
    check("guard_cnt", d_cnt, 8'd1);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("ovl_bit2", o_match, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("ovl_bit3", o_match, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("ovl_bit4", o_match, 1'b0);
    step(1'b1, 1'b1, 1'b0);
`ifdef SEQ_DETECT_OVERLAP_EN
    check("ovl_bit5", o_match, 1'b1);
    check("ovl_cnt", o_cnt, 8'd2);
`else
    check("ovl_bit5", o_match, 1'b0);
    check("ovl_cnt", o_cnt, 8'd1);
`endif
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check("gap_idle", d_match, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    check("gap_bit4", d_match, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("gap_match", d_match, 1'b1);
    check("gap_cnt", d_cnt, 8'd1);
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      prefix("sat");
      step(1'b1, 1'b1, 1'b0);
      check("sat_match", s_match, 1'b1);
      check("sat_cnt", s_cnt, (k < 3) ? k : 3);
      check("sat_flag", s_sat, (k >= 3) ? 1'b1 : 1'b0);
    end
    check("sat_wide_cnt", {d_cnt, d_sat}, {8'd5, 1'b0});
    prefix("clr");
    step(1'b1, 1'b1, 1'b1);
    check("clr_match", {s_match, d_match}, 2'b00);
    check("clr_cnt", {s_cnt, d_cnt}, 10'd0);
    check("clr_sat", s_sat, 1'b0);
    do_reset();
    prefix("mid");
    step(1'b1, 1'b1, 1'b0);
    check("mid_pre_cnt", d_cnt, 8'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_async_cnt", d_cnt, 8'd0);
    @(negedge clk) reset = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check("mid_bit4", d_match, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mid_bit5", d_match, 1'b0);
    prefix("mid_full");
    step(1'b1, 1'b1, 1'b0);
    check("mid_match", d_match, 1'b1);
    check("mid_cnt", d_cnt, 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

- Serial pattern detector: the receive-side counterpart of the team's serial sequence generator.
- Samples a 1-bit stream (`din`, qualified by `en`) and raises a one-cycle `match` pulse each time the last `LEN` accepted bits equal `PATTERN`.
- Keeps a saturating count of matches.
- Sits directly on the generator's serial output; default parameters recognise the generator's 5-bit burst `0,0,1,0,1`.

## Interface
- `LEN`, 5: pattern length in bits; legal range 2..32.
- `PATTERN`, 5'b00101: expected sequence, MSB = first bit received; width `LEN`.
- `CNT_W`, 8: width of the match counter; legal range 1..32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `din`  in  1  serial data bit.
- `en`  in  1  when high, `din` is accepted this cycle; when low, no state change (except `clear`).
- `clear`  in  1  synchronous clear of history, fill level, counter and outputs.
- `match`  out  1  registered one-cycle pulse; reset value 0.
- `match_count`  out  `CNT_W`  number of matches since reset/clear, saturating; reset value 0.
- `count_sat`  out  1  high while `match_count` is all ones; reset value 0.

## Operation
- **Internal state:**
  - History shift register `hist[LEN-1:0]`.
  - Fill counter `fill`, 0..`LEN`, saturating at `LEN`.
- **Accepted bit** (`en`=1, `clear`=0):
  - `hist` <= {`hist[LEN-2:0]`, `din`}.
  - `fill` increments, saturating at `LEN`.
- **Match condition** (combinational, same cycle): `en`=1, `clear`=0, `fill` >= `LEN`-1, and {`hist[LEN-2:0]`, `din`} == `PATTERN`.
- **Fill guard:** no match is possible until `LEN` bits have been accepted since reset/clear. The reset-zero history never stands in for received bits.
- **On match:**
  - `match` <= 1 for exactly one cycle.
  - `match_count` <= `match_count`+1 unless already all ones, in which case it holds.
- **`match` when no match:** `match` <= 0 on every edge without a match, including edges with `en`=0.
- **`count_sat`:** registered, equal to (`match_count` == all ones) after each update.
- **`en`=0:** `hist`, `fill`, `match_count` hold; `din` ignored.
- **`clear`=1:**
  - `hist`, `fill`, `match`, `match_count`, `count_sat` all <= 0 on that edge.
  - The `din` presented in that cycle is discarded even if `en`=1.
  - `clear` has priority over any match in the same cycle.
- **Reset asserted mid-stream:** immediate asynchronous zeroing of all state. The first match after release needs `LEN` fresh accepted bits.
- **Width rules:** `PATTERN` is truncated/zero-extended to `LEN` bits. The counter never wraps.

## Timing
- **Latency:** `match` rises on the edge that accepts the final pattern bit and is visible the following cycle. One cycle from last bit sampled to pulse.
- **`match_count` update:** on the same edge as `match` rising.
- **Back-to-back matches** (only possible with overlap) produce consecutive high cycles of `match`, one per accepted matching bit.
- **Throughput:** one bit per cycle. No backpressure; `en` is the only qualifier.
- **Chaining:** with the generator's output wired to `din` and `en`=1, `match` pulses one cycle after the generator emits its fifth burst bit.

## Configuration
- **Macro:** `SEQ_DETECT_OVERLAP_EN`.
- **Defined:** overlapping detection. After a match, `fill` stays at `LEN` and `hist` keeps the matched bits, so a pattern suffix may serve as the next pattern's prefix.
- **Undefined:**
  - Non-overlapping detection. On a match edge, `fill` <= 0; the `hist` contents are don't-care.
  - The next match requires `LEN` newly accepted bits.
- Default patterns without self-overlap (e.g. 00101) behave identically in both builds.

## Test plan
- **Default burst:** reset, `en`=1, drive 0,0,1,0,1 -> `match`=1 only in the cycle after bit 5; `match_count`=1; bits 1–4 give `match`=0.
- **Fill guard:** after reset, drive 1,0,1 then idle 0s -> no `match` (only 3 bits accepted before pattern end); then 0,0,1,0,1 -> one `match`, `match_count`=1.
- **Overlap:** `LEN`=3, `PATTERN`=3'b101, drive 1,0,1,0,1:
  - With `SEQ_DETECT_OVERLAP_EN`: matches after bits 3 and 5, `match_count`=2.
  - Without the macro: match after bit 3 only, `match_count`=1.
- **`en` gap:** drive 0,0,1 with `en`=1, hold `en`=0 for 4 cycles with `din` toggling, then 0,1 with `en`=1 -> single `match` after final bit; no state change during gap.
- **Saturation and clear:**
  - `CNT_W`=2: produce 5 bursts -> `match_count` stops at 3 and `count_sat`=1 from the third match on.
  - Then `clear`=1 together with the final bit of a sixth burst -> no `match`, `match_count`=0, `count_sat`=0.
- **Reset mid-pattern:** drive 0,0,1, assert `reset` asynchronously mid-cycle, release, drive 0,1 -> no `match`; a subsequent full 0,0,1,0,1 -> `match`, `match_count`=1.
